// File: rtl/ysyx_25040111_pkg.sv
// Shared definitions for the I-cache refill responder and its perf counters.
package ysyx_25040111_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    AR   = 2'd1,
    R    = 2'd2,
    DONE = 2'd3
  } refill_state_t;

  localparam logic [1:0] AXI_RESP_OKAY = 2'b00;

  localparam int unsigned SAT_MAX_W = 64;

  // Increment v, clamping at the all-ones value of a w-bit counter.
  function automatic logic [SAT_MAX_W-1:0] sat_inc(input logic [SAT_MAX_W-1:0] v,
                                                   input int unsigned w);
    logic [SAT_MAX_W-1:0] lim;
    lim = (w >= SAT_MAX_W) ? '1 : ((SAT_MAX_W'(1) << w) - SAT_MAX_W'(1));
    return (v >= lim) ? lim : v + SAT_MAX_W'(1);
  endfunction

endpackage

// File: rtl/ysyx_25040111_sat_cnt.sv
// Saturating up-counter: sticks at all-ones instead of wrapping.
module ysyx_25040111_sat_cnt
  import ysyx_25040111_pkg::*;
#(
  parameter int unsigned W = 32
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         inc,
  output logic [W-1:0] value
);

  always_ff @(posedge clock) begin
    if (!reset) begin
      value <= '0;
    end else if (inc) begin
      value <= W'(sat_inc(SAT_MAX_W'(value), W));
    end
  end

endmodule

// File: rtl/ysyx_25040111_refill_rsp.sv
// I-cache refill responder: turns a one-cycle refill request into a single-beat
// AXI4-Lite read and returns the word with a one-cycle rok pulse.
module ysyx_25040111_refill_rsp
  import ysyx_25040111_pkg::*;
#(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32,
  parameter int unsigned CNT_W  = 32
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              rstart,
  input  logic [ADDR_W-1:0] addr,
  output logic              rok,
  output logic [DATA_W-1:0] rdata,
  output logic              rerr,
  output logic [ADDR_W-1:0] araddr,
  output logic              arvalid,
  input  logic              arready,
  input  logic [DATA_W-1:0] m_rdata,
  input  logic [1:0]        rresp,
  input  logic              rvalid,
  output logic              rready,
  output logic [CNT_W-1:0]  perf_req,
  output logic [CNT_W-1:0]  perf_cyc
);

  refill_state_t state_q;
  refill_state_t state_d;

  logic arvalid_d;
  logic rready_d;
  logic rok_d;
  logic load_addr;
  logic load_data;
  logic inc_req;
  logic inc_cyc;

  // Byte offset is dropped when forming the word-aligned AXI address.
  logic unused_addr_lo;
  assign unused_addr_lo = ^addr[1:0];

  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Requests arriving in AR or R are dropped; only IDLE and DONE accept one.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (rstart)  state_d = AR;
      AR:      if (arready) state_d = R;
      R:       if (rvalid)  state_d = DONE;
      DONE:    state_d = rstart ? AR : IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Output values for the next cycle, decoded from the next state so the
  // registered outputs line up with the state they belong to.
  always_comb begin
    arvalid_d = 1'b0;
    rready_d  = 1'b0;
    rok_d     = 1'b0;
    load_addr = 1'b0;
    load_data = 1'b0;
    arvalid_d = (state_d == AR);
    rready_d  = (state_d == R);
    rok_d     = (state_d == DONE);
    load_addr = rstart && ((state_q == IDLE) || (state_q == DONE));
    load_data = (state_q == R) && rvalid;
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      arvalid <= 1'b0;
      rready  <= 1'b0;
      rok     <= 1'b0;
      rerr    <= 1'b0;
      rdata   <= '0;
      araddr  <= '0;
    end else begin
      arvalid <= arvalid_d;
      rready  <= rready_d;
      rok     <= rok_d;
      if (load_addr) begin
        araddr <= {addr[ADDR_W-1:2], 2'b00};
      end
      if (load_data) begin
        rdata <= m_rdata;
        rerr  <= (rresp != AXI_RESP_OKAY);
      end
    end
  end

  assign inc_req = (state_q == DONE);
  assign inc_cyc = (state_q == AR) || (state_q == R);

  ysyx_25040111_sat_cnt #(
    .W(CNT_W)
  ) u_perf_req (
    .clock(clock),
    .reset(reset),
    .inc  (inc_req),
    .value(perf_req)
  );

  ysyx_25040111_sat_cnt #(
    .W(CNT_W)
  ) u_perf_cyc (
    .clock(clock),
    .reset(reset),
    .inc  (inc_cyc),
    .value(perf_cyc)
  );

endmodule
